// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, ALU codes and control-bundle layout shared by the ID stage
package ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b1000;

   // Bit order of the control bundle, MSB first
   typedef struct packed {
      logic alu_src;
      logic mem_to_reg;
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic branch;
   } ctrl_t;

   function automatic logic op_uses_rs2(input logic [6:0] op);
      return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
   endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// rtl/ctrl_decode_comb.sv - pure combinational instruction to control/immediate decoder
module ctrl_decode_comb
   import ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     i_instr,
   output ctrl_t           o_ctrl,
   output logic [3:0]      o_alu_ctrl,
   output logic [XLEN-1:0] o_imm,
   output logic            o_illegal,
   output logic            o_uses_rs2
);

   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic [31:0] w_imm32;

   assign w_opcode   = i_instr[6:0];
   assign w_funct3   = i_instr[14:12];
   assign o_uses_rs2 = op_uses_rs2(w_opcode);
   // Sign extension beyond 32 bits comes from instr[31] through the signed cast
   assign o_imm      = XLEN'($signed(w_imm32));

   always_comb begin
      o_ctrl     = '0;
      o_alu_ctrl = ALU_ADD;
      o_illegal  = 1'b0;
      w_imm32    = '0;
      case (w_opcode)
         OP_R: begin
            o_ctrl.reg_write = 1'b1;
            o_alu_ctrl       = {i_instr[30], w_funct3};
         end
         OP_I: begin
            o_ctrl.reg_write = 1'b1;
            o_ctrl.alu_src   = 1'b1;
            o_alu_ctrl       = {(w_funct3 == 3'b101) ? i_instr[30] : 1'b0, w_funct3};
            w_imm32          = {{20{i_instr[31]}}, i_instr[31:20]};
         end
         OP_LOAD: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.mem_read   = 1'b1;
            o_ctrl.mem_to_reg = 1'b1;
            o_ctrl.alu_src    = 1'b1;
            w_imm32           = {{20{i_instr[31]}}, i_instr[31:20]};
         end
         OP_STORE: begin
            o_ctrl.mem_write = 1'b1;
            o_ctrl.alu_src   = 1'b1;
            w_imm32          = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         end
         OP_BRANCH: begin
            o_ctrl.branch = 1'b1;
            o_alu_ctrl    = ALU_SUB;
            w_imm32       = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                             i_instr[30:25], i_instr[11:8], 1'b0};
         end
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/ctrl_decode_stage.sv
// rtl/ctrl_decode_stage.sv - registered ID stage with handshake, flush, load-use interlock and stall counter
module ctrl_decode_stage
   import ctrl_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int RA_W   = 5,
   parameter int ALUC_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       ReadInstruction,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [RA_W-1:0]   ReadReg1Address,
   output logic [RA_W-1:0]   ReadReg2Address,
   output logic [RA_W-1:0]   WriteRegAddress,
   output logic [XLEN-1:0]   Immediate,
   output logic              ALU_Src,
   output logic              MemtoReg,
   output logic              RegWrite,
   output logic              MemRead,
   output logic              MemWrite,
   output logic              Branch,
   output logic [ALUC_W-1:0] ALU_Control,
   output logic              illegal,
   output logic [CNT_W-1:0]  stall_count
);

   ctrl_t             w_ctrl;
   logic [3:0]        w_alu4;
   logic [XLEN-1:0]   w_imm;
   logic              w_illegal;
   logic              w_uses_rs2;
   logic [RA_W-1:0]   w_rs1;
   logic [RA_W-1:0]   w_rs2;
   logic [RA_W-1:0]   w_rd;
   logic              w_hazard;
   logic              w_accept;

   logic              r_valid;
   logic [RA_W-1:0]   r_rs1;
   logic [RA_W-1:0]   r_rs2;
   logic [RA_W-1:0]   r_rd;
   logic [XLEN-1:0]   r_imm;
   ctrl_t             r_ctrl;
   logic [ALUC_W-1:0] r_aluc;
   logic              r_illegal;
   logic [CNT_W-1:0]  r_cnt;

   ctrl_decode_comb #(.XLEN(XLEN)) u_dec (
      .i_instr    (ReadInstruction),
      .o_ctrl     (w_ctrl),
      .o_alu_ctrl (w_alu4),
      .o_imm      (w_imm),
      .o_illegal  (w_illegal),
      .o_uses_rs2 (w_uses_rs2)
   );

   assign w_rs1 = RA_W'(ReadInstruction[19:15]);
   assign w_rs2 = RA_W'(ReadInstruction[24:20]);
   assign w_rd  = RA_W'(ReadInstruction[11:7]);

   // Held load whose destination feeds the offered instruction must leave before it enters
   assign w_hazard = r_valid & r_ctrl.mem_read & (r_rd != '0) &
                     ((r_rd == w_rs1) | ((r_rd == w_rs2) & w_uses_rs2));

   assign in_ready = !rst & !flush & !w_hazard & (!r_valid | out_ready);
   assign w_accept = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_rs1     <= '0;
         r_rs2     <= '0;
         r_rd      <= '0;
         r_imm     <= '0;
         r_ctrl    <= '0;
         r_aluc    <= '0;
         r_illegal <= 1'b0;
         r_cnt     <= '0;
      end else begin
         if (flush) begin
            r_valid <= 1'b0;
         end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_rs1     <= w_rs1;
            r_rs2     <= w_rs2;
            r_rd      <= w_rd;
            r_imm     <= w_imm;
            r_ctrl    <= w_ctrl;
            r_aluc    <= ALUC_W'(w_alu4);
            r_illegal <= w_illegal;
         end else if (out_ready) begin
            r_valid <= 1'b0;
         end
         if (in_valid & w_hazard & ~&r_cnt) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign out_valid       = r_valid;
   assign ReadReg1Address = r_rs1;
   assign ReadReg2Address = r_rs2;
   assign WriteRegAddress = r_rd;
   assign Immediate       = r_imm;
   assign ALU_Src         = r_ctrl.alu_src;
   assign MemtoReg        = r_ctrl.mem_to_reg;
   assign RegWrite        = r_ctrl.reg_write;
   assign MemRead         = r_ctrl.mem_read;
   assign MemWrite        = r_ctrl.mem_write;
   assign Branch          = r_ctrl.branch;
   assign ALU_Control     = r_aluc;
   assign illegal         = r_illegal;
   assign stall_count     = r_cnt;

endmodule
